id_scoreboard_ctrl: RTL
=======================

// Module: id_scoreboard_ctrl
// PURPOSE
//  Interlock/scheduler for the ID stage. Tracks in-flight register writes in a per-register
//  scoreboard of up/down counters, stalls ID when a source operand (incl. branch compare
//  operands) is still pending, inserts EX bubbles, flushes IF/ID on taken branches, and
//  drains the pipeline on request. Sits beside the ID-stage decoder/register file.
// PARAMETERS
//  NUM_REGS  32  architectural registers; r0 is never tracked
//  REG_W     5   register index width (log2 NUM_REGS)
//  CNT_W     2   per-register in-flight counter width; max in-flight = 2**CNT_W-1
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  id_valid     in   1      ID holds a valid instruction
//  id_rs        in   REG_W  source reg 1 (instr[25:21])
//  id_rt        in   REG_W  source reg 2 (instr[20:16])
//  id_use_rs    in   1      instruction reads rs
//  id_use_rt    in   1      instruction reads rt
//  id_wr_en     in   1      instruction writes a register
//  id_wr_reg    in   REG_W  destination after RegDst select (rt/rd/31)
//  id_is_branch in   1      beq/bne resolved in ID
//  id_br_taken  in   1      branch outcome from ID comparator
//  wb_wr_en     in   1      WB writes the register file this cycle
//  wb_wr_reg    in   REG_W  WB destination
//  flush_req    in   1      request a full pipeline drain (1-cycle pulse)
//  stall_id     out  1      hold PC and IF/ID
//  bubble_ex    out  1      load NOP into ID/EX
//  flush_if     out  1      clear IF/ID (taken branch)
//  issue        out  1      ID instruction accepted this cycle
//  drain_done   out  1      1-cycle pulse: drain complete
//  sb_err       out  1      sticky: scoreboard underflow seen
// BEHAVIOUR
//  Reset (rst=0): all counters 0, state RUN, sb_err=0, drain_done=0; stall_id=1, issue=0,
//   bubble_ex=1, flush_if=0 forced while rst=0.
//  hazard = (id_use_rs & rs!=0 & cnt[rs]!=0) | (id_use_rt & rt!=0 & cnt[rt]!=0)
//  full   = id_wr_en & id_wr_reg!=0 & cnt[id_wr_reg]==MAX
//  RUN:  issue = id_valid & ~hazard & ~full; stall_id = bubble_ex = id_valid & ~issue.
//   flush_if = issue & id_is_branch & id_br_taken (same cycle, combinational).
//   Branch with pending operand stalls like any hazard; it never flushes while stalled.
//  Counter update (registered, every cycle incl. DRAIN):
//   inc = issue & id_wr_en & id_wr_reg!=0 -> cnt[id_wr_reg]+1
//   dec = wb_wr_en & wb_wr_reg!=0 -> cnt[wb_wr_reg]-1
//   inc & dec same reg -> counter unchanged. dec at 0 -> counter stays 0, sb_err<=1.
//   Writes to r0 never tracked; r0 reads never hazard.
//  Latency: WB decrement visible to hazard next cycle (no same-cycle WB bypass).
//  FSM {RUN, DRAIN}, 1-bit state register:
//   RUN -> DRAIN on flush_req (the current cycle still issues normally).
//   DRAIN: issue=0, stall_id=1, bubble_ex=1, flush_if=0; WB decrements continue.
//   DRAIN -> RUN when all counters==0 (after this cycle's update); drain_done=1 that cycle
//   (registered, exactly one cycle). flush_req in DRAIN ignored.
//  rst asserted mid-DRAIN: immediate return to RUN, counters cleared, no drain_done.
// STRUCTURE
//  Package mips_pkg: NUM_REGS, REG_W, REG_ZERO=0, REG_RA=31, state enum {ST_RUN, ST_DRAIN}.
//  Sub-module sb_counter (CNT_W-bit saturating up/down counter, inc/dec/clr, underflow flag),
//   instantiated NUM_REGS-1 times via generate (r1..r31); top holds hazard logic and FSM.
// TESTING
//  1 rst=0 for 3 clk then release, id_valid=0 -> stall_id=0, all cnt=0, sb_err=0.
//  2 issue wr r8, next ID reads rs=8 -> stall_id=bubble_ex=1 until wb r8; issue cycle after WB.
//  3 issue wr r9 x3 (no WB), 4th wr r9 -> full stall; one wb r9 -> 4th issues next cycle.
//  4 beq rs=5 rt=6 no pending, id_br_taken=1 -> issue=1, flush_if=1 same cycle; with r5
//    pending -> flush_if=0 until resolved.
//  5 inc and wb dec on r3 same cycle -> cnt[r3] unchanged; wb r4 at cnt 0 -> sb_err=1 sticky.
//  6 flush_req with 2 in flight -> DRAIN, issue=0; drain_done one cycle after last WB count hits 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the ID-stage scoreboard.
//   NUM_REGS  architectural register count (r0 hard-wired, never tracked)
//   REG_W     register index width
//   REG_ZERO  index of the hard-wired zero register
//   REG_RA    index of the link register (jal destination)
//   state_e   interlock controller state
package mips_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_W    = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_W-1:0] REG_RA   = 5'd31;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/sb_counter.sv
// Per-register in-flight write counter.
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset (counter -> 0)
//   clr_i        synchronous clear (wins over inc/dec)
//   inc_i        one more write in flight
//   dec_i        one write retired
//   cnt_o        current count
//   cnt_nxt_o    count after this cycle's update
//   underflow_o  dec requested while count is already 0 (count stays 0)
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      // Saturate rather than wrap; the controller never issues into a full counter.
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) underflow_o = 1'b1;
      else             cnt_d       = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// ID-stage interlock: scoreboard of in-flight register writes, hazard stall,
// EX bubble insertion, taken-branch IF/ID flush and pipeline drain.
//   clk, rst                  clock / asynchronous active-low reset
//   id_*                      instruction currently in ID (sources, destination, branch)
//   wb_wr_en, wb_wr_reg       register-file write retiring in WB
//   flush_req                 pulse: drain all in-flight writes
//   stall_id, bubble_ex       hold PC and IF/ID, load NOP into ID/EX
//   flush_if                  clear IF/ID on an issued taken branch
//   issue                     ID instruction accepted this cycle
//   drain_done                one-cycle pulse when a drain completes
//   sb_err                    sticky scoreboard underflow flag
module id_scoreboard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_branch,
  input  logic             id_br_taken,
  input  logic             wb_wr_en,
  input  logic [REG_W-1:0] wb_wr_reg,
  input  logic             flush_req,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             issue,
  output logic             drain_done,
  output logic             sb_err
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0]    cnt     [NUM_REGS];
  logic [CNT_W-1:0]    cnt_nxt [NUM_REGS-1:1];
  logic [NUM_REGS-1:1] inc_vec, dec_vec, uflow_vec, nz_nxt_vec;

  logic   inc_en, dec_en, hazard, full, all_zero_nxt;
  state_e state_q, state_d;
  logic   drain_done_q, drain_done_d;
  logic   sb_err_q, sb_err_d;

  // r0 is hard-wired: its count reads as zero so it can never raise a hazard.
  assign cnt[0] = '0;

  assign inc_en = issue && id_wr_en && (id_wr_reg != REG_ZERO);
  assign dec_en = wb_wr_en && (wb_wr_reg != REG_ZERO);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    assign inc_vec[r] = inc_en && (id_wr_reg == REG_W'(r));
    assign dec_vec[r] = dec_en && (wb_wr_reg == REG_W'(r));

    sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i       (clk),
      .rst_ni      (rst),
      .clr_i       (1'b0),
      .inc_i       (inc_vec[r]),
      .dec_i       (dec_vec[r]),
      .cnt_o       (cnt[r]),
      .cnt_nxt_o   (cnt_nxt[r]),
      .underflow_o (uflow_vec[r])
    );

    assign nz_nxt_vec[r] = (cnt_nxt[r] != '0);
  end

  assign all_zero_nxt = ~|nz_nxt_vec;

  // No WB bypass: a retiring write clears the hazard only from the next cycle.
  assign hazard = (id_use_rs && (id_rs != REG_ZERO) && (cnt[id_rs] != '0)) ||
                  (id_use_rt && (id_rt != REG_ZERO) && (cnt[id_rt] != '0));
  assign full   = id_wr_en && (id_wr_reg != REG_ZERO) && (cnt[id_wr_reg] == CntMax);

  // Handshake outputs are forced to the safe "stalled" pattern while reset is held.
  always_comb begin
    issue    = 1'b0;
    stall_id = 1'b1;
    flush_if = 1'b0;
    if (rst && (state_q == ST_RUN)) begin
      issue    = id_valid && !hazard && !full;
      stall_id = id_valid && !issue;
      flush_if = issue && id_is_branch && id_br_taken;
    end
  end

  assign bubble_ex = stall_id;

  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (flush_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (all_zero_nxt) begin
          state_d      = ST_RUN;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign sb_err_d = sb_err_q || (|uflow_vec);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      drain_done_q <= 1'b0;
      sb_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_done_q <= drain_done_d;
      sb_err_q     <= sb_err_d;
    end
  end

  assign drain_done = drain_done_q;
  assign sb_err     = sb_err_q;

endmodule
